// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and widths for the memory port arbiter
package mem_arb_pkg;
  localparam int STREAK_W = 4;
  typedef enum logic {IDLE, WAIT} arb_state_e;
  typedef enum logic [1:0] {NONE, FETCH, DATA} arb_owner_e;
endpackage

// File: rtl/mem_arb_streak_ctr.sv
// mem_arb_streak_ctr: counts consecutive data grants taken while fetch waits, forcing fetch at the limit
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hs,
  input  logic data_hs,
  input  logic if_req,
  output logic fetch_force
);
  logic [STREAK_W-1:0] streak;
  assign fetch_force = streak == STREAK_W'(MAX_STREAK);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) streak <= '0;
    else if (hs) streak <= (data_hs && if_req) ? (fetch_force ? streak : streak + 1'b1) : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with anti-starvation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            proto_err
);
  arb_state_e state, state_n;
  arb_owner_e owner, owner_n;
  logic win, sel_d, sel_f, hs, fetch_force;
  // Reset gates the issue window so nothing leaks onto the port while held in reset
  assign win   = reset_n && (state == IDLE || m_rvalid);
  assign sel_d = win && d_req && !(if_req && fetch_force);
  assign sel_f = win && !sel_d && if_req;
  assign m_req   = sel_d | sel_f;
  assign m_we    = sel_d & d_we;
  assign m_be    = sel_d ? d_be : sel_f ? '1 : '0;
  assign m_addr  = sel_d ? d_addr : sel_f ? if_addr : '0;
  assign m_wdata = sel_d ? d_wdata : '0;
  assign hs     = m_req & m_gnt;
  assign d_gnt  = hs & sel_d;
  assign if_gnt = hs & sel_f;
  assign if_rvalid = state == WAIT && m_rvalid && owner == FETCH;
  assign d_rvalid  = state == WAIT && m_rvalid && owner == DATA;
  assign if_rdata  = if_rvalid ? m_rdata : '0;
  assign d_rdata   = d_rvalid ? m_rdata : '0;
  mem_arb_streak_ctr #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .clk(clk), .reset_n(reset_n), .hs(hs), .data_hs(d_gnt), .if_req(if_req), .fetch_force(fetch_force)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= NONE;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      proto_err <= proto_err | (state == IDLE && m_rvalid);
    end
  always_comb begin
    state_n = hs ? WAIT : (state == WAIT && m_rvalid) ? IDLE : state;
    owner_n = hs ? (sel_d ? DATA : FETCH) : (state == WAIT && m_rvalid) ? NONE : owner;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of selection, grants, routing, starvation and reset behaviour
module tb_mem_port_arbiter;
  logic clk = 0, reset_n = 0;
  logic if_req = 0, d_req = 0, d_we = 0, m_gnt = 0, m_rvalid = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] d_be = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, proto_err;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_be;
  int errs = 0, checks = 0;
  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    if_req = 1; d_req = 1; d_addr = 32'h55;
    #4;
    chk("rst_m_req", m_req, 0); chk("rst_gnt", {if_gnt, d_gnt}, 0); chk("rst_m_addr", m_addr, 0);
    chk("rst_m_be", m_be, 0); chk("rst_rvalid", {if_rvalid, d_rvalid}, 0); chk("rst_perr", proto_err, 0);
    tick; if_req = 0; d_req = 0; reset_n = 1;
    tick;
    // single fetch
    if_req = 1; if_addr = 32'h100; m_gnt = 1; #4;
    chk("f_if_gnt", if_gnt, 1); chk("f_d_gnt", d_gnt, 0); chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_be", m_be, 4'hf); chk("f_m_we", m_we, 0);
    tick; if_req = 0; m_gnt = 0; #4;
    chk("f_wait_m_req", m_req, 0);
    tick; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #4;
    chk("f_if_rvalid", if_rvalid, 1); chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_d_idle", {d_rvalid, d_rdata}, 0);
    tick; m_rvalid = 0; m_rdata = 0; #4;
    chk("f_after_perr", proto_err, 0); chk("f_after_rvalid", if_rvalid, 0);
    // write
    tick; d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234; m_gnt = 1; #4;
    chk("w_d_gnt", d_gnt, 1); chk("w_m_we", m_we, 1); chk("w_m_be", m_be, 4'b0011);
    chk("w_m_addr", m_addr, 32'h200); chk("w_m_wdata", m_wdata, 32'h1234);
    tick; d_req = 0; d_we = 0; m_gnt = 0;
    tick; m_rvalid = 1; #4;
    chk("w_ack", {if_rvalid, d_rvalid}, 2'b01);
    tick; m_rvalid = 0;
    // contention then back-to-back
    tick; if_req = 1; if_addr = 32'h300; d_req = 1; d_addr = 32'h400; m_gnt = 1; #4;
    chk("c_gnt", {if_gnt, d_gnt}, 2'b01); chk("c_m_addr", m_addr, 32'h400);
    tick; d_req = 0; #4;
    chk("c_wait_gnt", {if_gnt, m_req}, 0);
    tick; m_rvalid = 1; m_rdata = 32'hCAFE0001; #4;
    chk("b2b_d_rvalid", {if_rvalid, d_rvalid}, 2'b01); chk("b2b_d_rdata", d_rdata, 32'hCAFE0001);
    chk("b2b_if_gnt", if_gnt, 1); chk("b2b_m_addr", m_addr, 32'h300);
    tick; if_req = 0; m_gnt = 0; m_rdata = 32'h11112222; #4;
    chk("b2b_if_rvalid", {if_rvalid, d_rvalid}, 2'b10); chk("b2b_if_rdata", if_rdata, 32'h11112222);
    tick; m_rvalid = 0; m_rdata = 0;
    // starvation: 1-cycle latency, both held high
    tick; if_req = 1; d_req = 1; m_gnt = 1;
    for (int i = 0; i < 10; i++) begin
      m_rvalid = (i != 0); #4;
      chk($sformatf("s_gnt%0d", i), {if_gnt, d_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
      tick;
    end
    if_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 1; #4;
    chk("s_drain", {if_rvalid, d_rvalid}, 2'b10);
    tick; m_rvalid = 0;
    // reset while a transaction is outstanding
    tick; d_req = 1; d_addr = 32'h500; m_gnt = 1; #4;
    chk("r_d_gnt", d_gnt, 1);
    tick; d_req = 0; m_gnt = 0; #2;
    reset_n = 0; if_req = 1; m_gnt = 1; m_rvalid = 1; #2;
    chk("r_in_m_req", m_req, 0); chk("r_in_gnt", {if_gnt, d_gnt}, 0);
    chk("r_in_rvalid", {if_rvalid, d_rvalid}, 0); chk("r_in_perr", proto_err, 0);
    tick; reset_n = 1; if_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h77; #4;
    chk("r_late_rvalid", {if_rvalid, d_rvalid}, 0); chk("r_late_rdata", d_rdata, 0);
    tick; m_rvalid = 0; #4;
    chk("r_perr_set", proto_err, 1);
    tick; tick; #4;
    chk("r_perr_sticky", proto_err, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
